// File: rtl/ks_add16_gates.sv
// Registered Kogge-Stone prefix adder built from and/or/xor gate primitives.
// Optional carry-in port enabled by defining KS_ADD16_CIN_EN.
module ks_add16_gates #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
`ifdef KS_ADD16_CIN_EN
  input  logic             cin,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0]             w_g;
  logic [WIDTH-1:0]             w_h;
  logic [WIDTH-1:0]             w_sum;
  logic [LEVELS:0][WIDTH-1:0]   w_gg;
  logic [LEVELS-1:0][WIDTH-1:0] w_pp;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;

  genvar i, k;

  // Per-bit generate, OR-propagate and half-sum.
  for (i = 0; i < WIDTH; i++) begin : g_bit_terms
    and u_g (w_g[i], a[i], b[i]);
    or  u_p (w_pp[0][i], a[i], b[i]);
    xor u_h (w_h[i], a[i], b[i]);
    if (i > 0) begin : g_pass_g
      assign w_gg[0][i] = w_g[i];
    end
  end

`ifdef KS_ADD16_CIN_EN
  logic w_pcin;
  and u_pcin (w_pcin, w_pp[0][0], cin);
  or  u_gcin (w_gg[0][0], w_g[0], w_pcin);
  xor u_s0   (w_sum[0], w_h[0], cin);
`else
  assign w_gg[0][0] = w_g[0];
  assign w_sum[0]   = w_h[0];
`endif

  for (k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned D = 1 << k;
    for (i = 0; i < WIDTH; i++) begin : g_col
      if (i >= D) begin : g_cell
        logic w_pg;
        and u_pg (w_pg, w_pp[k][i], w_gg[k][i-D]);
        or  u_gg (w_gg[k+1][i], w_gg[k][i], w_pg);
        // The final level needs no group propagate.
        if (k < LEVELS - 1) begin : g_p
          and u_pp (w_pp[k+1][i], w_pp[k][i], w_pp[k][i-D]);
        end
      end else begin : g_wire
        assign w_gg[k+1][i] = w_gg[k][i];
        if (k < LEVELS - 1) begin : g_p
          assign w_pp[k+1][i] = w_pp[k][i];
        end
      end
    end
  end

  for (i = 1; i < WIDTH; i++) begin : g_sum
    xor u_s (w_sum[i], w_h[i], w_gg[LEVELS][i-1]);
  end

  // Low-half propagates of the last level feed nothing.
  logic w_unused_p;
  assign w_unused_p = ^w_pp[LEVELS-1][WIDTH/2-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_co    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum <= w_sum;
        r_co  <= w_gg[LEVELS][WIDTH-1];
      end
    end
  end

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign co        = r_co;

endmodule

// File: tb/tb_ks_add16_gates.sv
// Directed and streaming checks for ks_add16_gates against a 17-bit a+b reference.
module tb_ks_add16_gates;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] sum;
  logic        co;
`ifdef KS_ADD16_CIN_EN
  logic        cin;
`endif

  int n_checks;
  int n_pass;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
  } vec_t;

  vec_t vecs[8];

  ks_add16_gates #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
`ifdef KS_ADD16_CIN_EN
    .cin      (cin),
`endif
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .sum      (sum),
    .co       (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] exp_res;
    logic [15:0] held_sum;
    logic        held_co;
    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, s: 16'h0000, c: 1'b1};
    vecs[1] = '{a: 16'h8000, b: 16'h8000, s: 16'h0000, c: 1'b1};
    vecs[2] = '{a: 16'h5555, b: 16'hAAAA, s: 16'hFFFF, c: 1'b0};
    vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, s: 16'hFFFE, c: 1'b1};
    vecs[4] = '{a: 16'h0000, b: 16'h0000, s: 16'h0000, c: 1'b0};
    vecs[5] = '{a: 16'h1234, b: 16'h4321, s: 16'h5555, c: 1'b0};
    vecs[6] = '{a: 16'h7FFF, b: 16'h0001, s: 16'h8000, c: 1'b0};
    vecs[7] = '{a: 16'h00FF, b: 16'h0F01, s: 16'h1000, c: 1'b0};

    // Reset held while valid operands are presented.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h1111;
`ifdef KS_ADD16_CIN_EN
    cin      = 1'b0;
`endif
    step();
    step();
    check("reset_sum", {16'h0, sum}, 32'h0);
    check("reset_co", {31'h0, co}, 32'h0);
    check("reset_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("first_sum", {16'h0, sum}, 32'h2345);
    check("first_co", {31'h0, co}, 32'h0);
    check("first_valid", {31'h0, out_valid}, 32'h1);

    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      step();
      check($sformatf("vec%0d_result", i), {15'h0, co, sum}, {15'h0, vecs[i].c, vecs[i].s});
      check($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'h1);
    end

    // Streaming: one new pair per cycle.
    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      exp_res = {1'b0, a} + {1'b0, b};
      step();
      check($sformatf("stream%0d_result", i), {15'h0, co, sum}, {15'h0, exp_res});
      check($sformatf("stream%0d_valid", i), {31'h0, out_valid}, 32'h1);
    end
    held_sum = sum;
    held_co  = co;
    in_valid = 1'b0;
    a        = 16'hA5A5;
    b        = 16'h5A5B;
    step();
    check("drop_valid", {31'h0, out_valid}, 32'h0);
    check("drop_hold", {15'h0, co, sum}, {15'h0, held_co, held_sum});
    step();
    check("drop_hold2", {15'h0, co, sum}, {15'h0, held_co, held_sum});

    // Asynchronous reset between edges while results flow.
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'h0002;
    step();
    check("pre_rst_result", {15'h0, co, sum}, 32'h10001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", {16'h0, sum}, 32'h0);
    check("async_rst_co", {31'h0, co}, 32'h0);
    check("async_rst_valid", {31'h0, out_valid}, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", {15'h0, out_valid, co, sum}, 32'h0);

`ifdef KS_ADD16_CIN_EN
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'h0000;
    cin      = 1'b1;
    step();
    check("cin_ripple", {15'h0, co, sum}, 32'h10000);
    a = 16'h0001;
    b = 16'h0001;
    step();
    check("cin_small", {15'h0, co, sum}, 32'h00003);
    in_valid = 1'b0;
    cin      = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ks_add16_gates.md
Name: ks_add16_gates

Overview:
- Registered 16-bit Kogge-Stone parallel-prefix adder built structurally from AN2, OR2 and XOR gate primitives.
- Produces a 16-bit sum and a carry-out one clock after the operands are presented.
- Serves as the datapath adder wherever a fast fixed-width unsigned add is needed.
- Comparison reference for verification: {co, sum} equals the 17-bit result of a + b.

Parameters:
- WIDTH, 16, operand width. Must be a power of two, at least 2. Prefix depth = log2(WIDTH), which is 4 at the default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a and b are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  sum and co hold a new result.
- sum  output  WIDTH  registered (a + b) mod 2^WIDTH.
- co  output  1  registered carry-out of bit WIDTH-1.

Behaviour:
- Reset: while rst_n = 0, sum = 0, co = 0 and out_valid = 0, taking effect immediately without waiting for a clock edge. Outputs stay at these values until the first accepted operand pair after release.
- Per-bit terms, one gate each:
  - g[i] = AN2(a[i], b[i]).
  - p[i] = OR2(a[i], b[i]). OR-propagate is intentional and valid for carry generation only.
  - h[i] = XOR(a[i], b[i]). Half-sum.
- Prefix cell, built from 2 AN2 and 1 OR2:
  - Gij = Gi | (Pi & Gj).
  - Pij = Pi & Pj.
- Prefix levels k = 0 .. log2(WIDTH)-1, distance d = 2^k:
  - Bit i >= d combines with bit i-d.
  - Bits i < d pass through unchanged as wires, with no gates.
  - The last level computes G only; its Pij output is left unused.
- Group carries: c[i] = G[i:0] after the final level.
- Sum and carry-out:
  - sum[0] = h[0].
  - sum[i] = XOR(h[i], c[i-1]) for i >= 1.
  - co = c[WIDTH-1].
- Timing: the adder core is purely combinational. The result is captured on the rising clk edge when in_valid = 1, so latency is exactly 1 cycle.
- out_valid is registered: it equals the previous cycle's in_valid.
- When in_valid = 0: sum and co hold their last values and out_valid goes to 0 on the next edge.
- Back-to-back operation: a new operand pair can be accepted every cycle (throughput 1 per cycle). There is no backpressure.
- Arithmetic is unsigned with wrap-around, and the carry goes only to co. Overflow of signed operands is not flagged.
- Reset asserted mid-operation: the in-flight result is discarded and out_valid = 0 immediately.
- Implementation constraints:
  - No behavioural '+' anywhere in the adder core.
  - Gate-level instances only, generated with generate loops.

Optional Feature:
- Macro KS_ADD16_CIN_EN.
- When defined:
  - Adds an input port cin (1 bit), sampled together with a and b.
  - cin is folded into bit 0: g'[0] = g[0] | (p[0] & cin).
  - sum[0] = XOR(h[0], cin).
  - Full result: {co, sum} = a + b + cin.
- When undefined:
  - No cin port exists, and the behaviour is exactly as in Behaviour (carry-in is 0).

Test Plan:
- Reset: hold rst_n = 0, then drive in_valid = 1 with a = 0x1234, b = 0x1111. Required: sum = 0, co = 0, out_valid = 0 for as long as reset is held. After release, one clock later: sum = 0x2345, co = 0, out_valid = 1.
- Full carry ripple: a = 0xFFFF, b = 0x0001. Required: sum = 0x0000, co = 1 after 1 cycle. Also a = 0x8000, b = 0x8000. Required: sum = 0x0000, co = 1.
- Full-propagate, no generate: a = 0x5555, b = 0xAAAA. Required: sum = 0xFFFF, co = 0. Then a = 0xFFFF, b = 0xFFFF. Required: sum = 0xFFFE, co = 1.
- Streaming: in_valid = 1 for 100 consecutive cycles with $random a and b. Required: every cycle, {co, sum} equals the 17-bit value a + b from the previous cycle, and out_valid stays 1. Then drop in_valid. Required: out_valid = 0 next cycle and sum and co hold their values.
- Reset mid-stream: assert rst_n = 0 asynchronously between clock edges while results are flowing. Required: sum, co and out_valid go to 0 immediately, with no clock edge needed.
- With KS_ADD16_CIN_EN defined: a = 0xFFFF, b = 0x0000, cin = 1. Required: sum = 0x0000, co = 1. Also a = 0x0001, b = 0x0001, cin = 1. Required: sum = 0x0003, co = 0.
